// File: rtl/dnn_batch_ctrl.sv
// dnn_batch_ctrl: run controller for the fixed-point DNN inference engine.
// It sequences next_tc / dnn_start / dnn_done / dnn_reset for every test
// case of a batch and scores each case with a 1-based argmax against the
// expected label, accumulating hit and test-case counts.
// Optional build macro: DNN_WAIT_TIMEOUT_EN. When defined, a WAIT-state
// timeout of TIMEOUT_CYCLES sets the sticky err flag and scores the case
// as a miss. When it is not defined, err is tied to 0.
module dnn_batch_ctrl #(
   parameter int DATA_WIDTH     = 8,
   parameter int NUM_OUT        = 10,
   parameter int NUM_TC         = 5000,
   parameter int CNT_WIDTH      = 16,
   parameter int Y_WIDTH        = 4,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          go,
   output logic                          busy,
   output logic                          next_tc,
   output logic                          dnn_start,
   output logic                          dnn_reset,
   input  logic                          dnn_done,
   input  logic [DATA_WIDTH*NUM_OUT-1:0] dnn_out,
   input  logic [Y_WIDTH-1:0]            exp_y,
   output logic [CNT_WIDTH-1:0]          hit_cnt,
   output logic [CNT_WIDTH-1:0]          tc_cnt,
   output logic [Y_WIDTH-1:0]            last_pred,
   output logic                          batch_done,
   output logic                          err
);

   localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_NEXT, S_START, S_WAIT, S_SCAN, S_SCORE, S_RST, S_FIN
   } state_t;

   state_t state_reg, state_next;

   // registered output pulses and their combinational next values
   logic busy_reg, next_tc_reg, dnn_start_reg, dnn_reset_reg, batch_done_reg;
   logic busy_next, next_tc_next, dnn_start_next, dnn_reset_next, batch_done_next;

   // datapath registers
   logic                          done_q;
   logic [DATA_WIDTH*NUM_OUT-1:0] snap_reg;
   logic signed [DATA_WIDTH-1:0]  max_conf_reg;
   logic [Y_WIDTH-1:0]            max_idx_reg;
   logic [IDX_W-1:0]              scan_idx_reg;
   logic [CNT_WIDTH-1:0]          hit_cnt_reg, tc_cnt_reg;
   logic [Y_WIDTH-1:0]            last_pred_reg;

   logic                          done_edge;
   logic                          timeout_hit;
   logic signed [DATA_WIDTH-1:0]  scan_elem;
   logic [Y_WIDTH-1:0]            cand_idx;

   // a fresh rising edge of dnn_done is required; a level held from before is ignored
   assign done_edge = dnn_done & ~done_q;
   // the snapshot shifts down one element per SCAN cycle, so element i sits at the bottom in cycle i
   assign scan_elem = snap_reg[DATA_WIDTH-1:0];
   assign cand_idx  = Y_WIDTH'(scan_idx_reg) + Y_WIDTH'(1);

   // saturating increment shared by both counters
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_WIDTH'(1);
   endfunction

`ifdef DNN_WAIT_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   logic [TO_W-1:0] wait_cnt_reg;
   logic            err_reg;

   // counter value k-1 in the k-th WAIT cycle, so the limit fires in cycle TIMEOUT_CYCLES
   assign timeout_hit = (state_reg == S_WAIT) && !done_edge &&
                        (wait_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));
   assign err = err_reg;

   // WAIT cycle counter (cleared on entry) and sticky timeout flag (cleared by go)
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt_reg <= '0;
         err_reg      <= 1'b0;
      end else begin
         if (state_reg == S_START)
            wait_cnt_reg <= '0;
         else if (state_reg == S_WAIT)
            wait_cnt_reg <= wait_cnt_reg + TO_W'(1);
         if (state_reg == S_IDLE && go)
            err_reg <= 1'b0;
         else if (timeout_hit)
            err_reg <= 1'b1;
      end
   end
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   // state register plus registered output pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= S_IDLE;
         busy_reg       <= 1'b0;
         next_tc_reg    <= 1'b0;
         dnn_start_reg  <= 1'b0;
         dnn_reset_reg  <= 1'b0;
         batch_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         busy_reg       <= busy_next;
         next_tc_reg    <= next_tc_next;
         dnn_start_reg  <= dnn_start_next;
         dnn_reset_reg  <= dnn_reset_next;
         batch_done_reg <= batch_done_next;
      end
   end

   // next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (go) state_next = (NUM_TC == 0) ? S_FIN : S_NEXT;
         S_NEXT:  state_next = S_START;
         S_START: state_next = S_WAIT;
         S_WAIT: begin
            if (done_edge)
               state_next = S_SCAN;
            else if (timeout_hit)
               state_next = S_RST;
         end
         S_SCAN:  if (scan_idx_reg == IDX_W'(NUM_OUT - 1)) state_next = S_SCORE;
         S_SCORE: state_next = S_RST;
         S_RST:   state_next = (tc_cnt_reg == CNT_WIDTH'(NUM_TC)) ? S_FIN : S_NEXT;
         S_FIN:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // outputs decoded from the next state so the registered pulses line up with their states
   always_comb begin
      busy_next       = (state_next != S_IDLE);
      next_tc_next    = (state_next == S_NEXT);
      dnn_start_next  = (state_next == S_START);
      dnn_reset_next  = (state_next == S_RST);
      batch_done_next = (state_next == S_FIN);
   end

   // snapshot, argmax scan and scoring datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done_q        <= 1'b0;
         snap_reg      <= '0;
         max_conf_reg  <= '0;
         max_idx_reg   <= '0;
         scan_idx_reg  <= '0;
         hit_cnt_reg   <= '0;
         tc_cnt_reg    <= '0;
         last_pred_reg <= '0;
      end else begin
         done_q <= dnn_done;
         case (state_reg)
            S_IDLE: begin
               if (go) begin
                  hit_cnt_reg   <= '0;
                  tc_cnt_reg    <= '0;
                  last_pred_reg <= '0;
               end
            end
            S_WAIT: begin
               if (done_edge) begin
                  snap_reg     <= dnn_out;
                  max_conf_reg <= '0;
                  max_idx_reg  <= '0;
                  scan_idx_reg <= '0;
               end else if (timeout_hit) begin
                  last_pred_reg <= '0;
                  tc_cnt_reg    <= sat_inc(tc_cnt_reg);
               end
            end
            S_SCAN: begin
               // strict compare keeps the lowest index on ties and 0 when nothing is positive
               if (scan_elem > max_conf_reg) begin
                  max_conf_reg <= scan_elem;
                  max_idx_reg  <= cand_idx;
               end
               snap_reg     <= snap_reg >> DATA_WIDTH;
               scan_idx_reg <= scan_idx_reg + IDX_W'(1);
            end
            S_SCORE: begin
               last_pred_reg <= max_idx_reg;
               if (max_idx_reg == exp_y)
                  hit_cnt_reg <= sat_inc(hit_cnt_reg);
               tc_cnt_reg <= sat_inc(tc_cnt_reg);
            end
            default: ;
         endcase
      end
   end

   assign busy       = busy_reg;
   assign next_tc    = next_tc_reg;
   assign dnn_start  = dnn_start_reg;
   assign dnn_reset  = dnn_reset_reg;
   assign batch_done = batch_done_reg;
   assign hit_cnt    = hit_cnt_reg;
   assign tc_cnt     = tc_cnt_reg;
   assign last_pred  = last_pred_reg;

endmodule

// File: doc/dnn_batch_ctrl.md
Name: dnn_batch_ctrl

Overview:
Synthesizable run controller for the fixed-point DNN inference engine (`dnn_sigmoid_fix`). It is the other end of the engine's control and result interface.
- Drives the test-case sequence: `next_tc`, then `dnn_start`, then waits for `dnn_done`, then `dnn_reset`.
- Consumes the engine's output vector, computes the 1-based argmax prediction and compares it with the expected label.
- Accumulates hit and test-case counts over a batch.
- Sits between the test-vector memory, the DNN engine and a status/readout path. It replaces software scoring in on-chip accuracy runs.

Parameters:
- DATA_WIDTH, 8, width of one signed DNN output element
- NUM_OUT, 10, number of DNN output elements (classes)
- NUM_TC, 5000, test cases per batch
- CNT_WIDTH, 16, width of `hit_cnt` and `tc_cnt`
- Y_WIDTH, 4, width of the expected label and of `last_pred`
- TIMEOUT_CYCLES, 65535, WAIT-state limit; used only when DNN_WAIT_TIMEOUT_EN is defined

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, asynchronous, active-low
- go  in  1  1-cycle pulse; starts a batch when idle
- busy  out  1  high from go acceptance until the FIN state exits
- next_tc  out  1  1-cycle pulse; advances the memory to the next X/y test case
- dnn_start  out  1  1-cycle pulse to the engine
- dnn_reset  out  1  1-cycle pulse to the engine
- dnn_done  in  1  engine completion level
- dnn_out  in  DATA_WIDTH*NUM_OUT  signed outputs; element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- exp_y  in  Y_WIDTH  expected label (1-based; 0 means none)
- hit_cnt  out  CNT_WIDTH  correct predictions this batch
- tc_cnt  out  CNT_WIDTH  test cases completed this batch
- last_pred  out  Y_WIDTH  prediction for the most recent test case
- batch_done  out  1  1-cycle pulse when the batch completes
- err  out  1  sticky timeout flag; constant 0 without the macro

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs are 0; the FSM goes to IDLE.
  - The snapshot registers and done_q are cleared.
  - Reset mid-operation abandons the batch; counts are not preserved.
- FSM states: IDLE, NEXT, START, WAIT, SCAN, SCORE, RST, FIN.
- IDLE:
  - go=1 clears hit_cnt, tc_cnt, last_pred and err, then goes to NEXT (or to FIN if NUM_TC==0).
  - go is ignored in every other state.
- NEXT: next_tc=1 for one cycle, then START.
- START: dnn_start=1 for one cycle, then WAIT.
- WAIT:
  - done_q registers dnn_done every cycle.
  - A rising edge (dnn_done=1, done_q=0) snapshots all NUM_OUT elements of dnn_out into internal registers, then SCAN.
  - A level already high on entry does not trigger the transition; a fresh edge is required.
- SCAN:
  - Takes NUM_OUT cycles, one snapshot element per cycle, index 0 upward.
  - max_conf starts at 0 and max_idx at 0.
  - If elem > max_conf (signed, strict): max_conf=elem and max_idx=i+1.
  - Ties keep the lowest index. All elements <=0 gives max_idx=0.
- SCORE:
  - last_pred=max_idx.
  - If max_idx==exp_y, hit_cnt increments, saturating at all-ones.
  - tc_cnt increments, also saturating.
  - exp_y is sampled in this cycle only.
- RST: dnn_reset=1 for one cycle. Go to FIN if tc_cnt==NUM_TC, else NEXT.
- FIN: batch_done=1 for one cycle, busy drops next cycle, then IDLE.
- Latency:
  - go accepted at cycle 0 → next_tc at cycle 1 → dnn_start at cycle 2.
  - Done edge at cycle d → SCORE at d+NUM_OUT+1 → dnn_reset at d+NUM_OUT+2 → next next_tc at d+NUM_OUT+3.
- Output pulses are registered. No two of next_tc, dnn_start and dnn_reset are ever high together.

Optional Feature:
DNN_WAIT_TIMEOUT_EN:
- Defined:
  - A cycle counter runs in WAIT and resets on entry.
  - Reaching TIMEOUT_CYCLES without a done edge sets err (sticky until the next go).
  - The test case then counts as a miss: last_pred=0, tc_cnt increments, hit_cnt is unchanged.
  - Flow continues to RST, so the engine is reset and the batch proceeds.
- Undefined: no counter; WAIT waits indefinitely; err is tied to 0.

Test Plan:
1. NUM_TC=3; engine model raises done 5 cycles after dnn_start with element index 3 = 40 and the rest 10; exp_y=4 → hit_cnt=3, tc_cnt=3, last_pred=4, exactly 3 pulses each of next_tc, dnn_start and dnn_reset, one batch_done, busy low afterwards.
2. Elements 2 and 7 both 50, rest 0; exp_y=3 → last_pred=3, hit counted; repeat with exp_y=8 → miss.
3. All elements -5 or 0, exp_y=5 → last_pred=0, hit_cnt unchanged, tc_cnt +1; exp_y=0 on the next case → hit.
4. dnn_done held high from before dnn_start → no SCAN until done falls and rises again; go pulsed during WAIT → ignored, counts unaffected.
5. rst=0 asserted mid-SCAN → all outputs 0 asynchronously, FSM in IDLE; a new go gives a clean batch with counts starting from 0.
6. With DNN_WAIT_TIMEOUT_EN defined and TIMEOUT_CYCLES=20, engine never signals done → err=1 after 20 WAIT cycles, tc_cnt +1, hit_cnt 0, dnn_reset pulse, batch continues.
